// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: divider FSM states, default width,
// divide-by-zero quotient constant and the HI/LO select encodings.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } div_state_e;

  // Quotient reported for a zero divisor (also what the restoring loop yields).
  localparam logic [MDU_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  // HI/LO write-port select, shared with the multiplier.
  typedef enum logic {
    HILO_SEL_LO = 1'b0,
    HILO_SEL_HI = 1'b1
  } hilo_sel_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: used for operand magnitudes and for
// sign correction of the divider results.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result_c
);

  assign result_c = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mdu_divider.sv
// Multicycle radix-2 restoring divider for DIV/DIVU; one quotient bit per
// clock, quotient to LO and remainder to HI, completion via busy/done.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e state, state_nxt;

  logic [CNT_W-1:0] iter,     iter_nxt;
  logic [WIDTH-1:0] rem_q,    rem_nxt;
  logic [WIDTH-1:0] dvd_q,    dvd_nxt;
  logic [WIDTH-1:0] dsr_q,    dsr_nxt;
  logic [WIDTH-1:0] raw_dvd,  raw_dvd_nxt;
  logic             q_neg,    q_neg_nxt;
  logic             r_neg,    r_neg_nxt;
  logic             zero_q,   zero_nxt;
  logic             busy_nxt, done_nxt, div_zero_nxt;
  logic [WIDTH-1:0] quotient_nxt, remainder_nxt;

  logic [WIDTH-1:0] abs_dividend, abs_divisor;
  logic [WIDTH-1:0] q_fixed, r_fixed;
  logic [WIDTH:0]   shifted, trial;

  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_dividend (
    .neg      (sign & dividend[WIDTH-1]),
    .value    (dividend),
    .result_c (abs_dividend)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_divisor (
    .neg      (sign & divisor[WIDTH-1]),
    .value    (divisor),
    .result_c (abs_divisor)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quotient (
    .neg      (q_neg),
    .value    (dvd_q),
    .result_c (q_fixed)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_remainder (
    .neg      (r_neg),
    .value    (rem_q),
    .result_c (r_fixed)
  );

  // One restoring step: shift the next dividend bit in, trial-subtract in WIDTH+1 bits.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (iter == LAST_ITER) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    iter_nxt      = iter;
    rem_nxt       = rem_q;
    dvd_nxt       = dvd_q;
    dsr_nxt       = dsr_q;
    raw_dvd_nxt   = raw_dvd;
    q_neg_nxt     = q_neg;
    r_neg_nxt     = r_neg;
    zero_nxt      = zero_q;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    div_zero_nxt  = div_zero;
    quotient_nxt  = quotient;
    remainder_nxt = remainder;
    case (state)
      IDLE: begin
        if (start) begin
          dvd_nxt     = abs_dividend;
          dsr_nxt     = abs_divisor;
          raw_dvd_nxt = dividend;
          q_neg_nxt   = sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg_nxt   = sign & dividend[WIDTH-1];
          zero_nxt    = (divisor == '0);
          rem_nxt     = '0;
          iter_nxt    = '0;
          busy_nxt    = 1'b1;
        end
      end
      CALC: begin
        rem_nxt  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_nxt  = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        iter_nxt = iter + CNT_W'(1);
      end
      FIN: begin
        // A zero divisor ignores sign: all-ones quotient, raw dividend remainder.
        quotient_nxt  = zero_q ? '1 : q_fixed;
        remainder_nxt = zero_q ? raw_dvd : r_fixed;
        div_zero_nxt  = zero_q;
        done_nxt      = 1'b1;
        busy_nxt      = 1'b0;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iter      <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      raw_dvd   <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      zero_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      iter      <= iter_nxt;
      rem_q     <= rem_nxt;
      dvd_q     <= dvd_nxt;
      dsr_q     <= dsr_nxt;
      raw_dvd   <= raw_dvd_nxt;
      q_neg     <= q_neg_nxt;
      r_neg     <= r_neg_nxt;
      zero_q    <= zero_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      div_zero  <= div_zero_nxt;
      quotient  <= quotient_nxt;
      remainder <= remainder_nxt;
    end
  end

endmodule

// File: tb/tb_mdu_divider.sv
// Self-checking bench for mdu_divider: directed corner cases plus randomized
// operands against an arithmetic reference model.
module tb_mdu_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int n_tests;
  int n_fail;

  mdu_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sign      (sign),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero for signed.
  task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b; z = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb); r = 32'(sa % sb); z = 1'b0;
    end
  endtask

  // Drive start at a falling edge; returns just after the accepting edge E0.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; sign = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen; busy must hold high until then.
  task automatic wait_done(input int first, output int edges, output logic busy_ok);
    edges = first;
    busy_ok = 1'b1;
    while (edges < 80) begin
      @(posedge clk); #1;
      edges++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic expect_result(input string tag, input logic s,
                               input logic [31:0] a, input logic [31:0] b,
                               input int edges, input logic busy_ok);
    logic [31:0] q, r;
    logic z;
    model(s, a, b, q, r, z);
    check({tag, "_lat"},  32'(edges), 32'd33);
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_bdrop"}, 32'(busy), 32'd0);
    check({tag, "_q"},    quotient, q);
    check({tag, "_r"},    remainder, r);
    check({tag, "_z"},    32'(div_zero), 32'(z));
  endtask

  task automatic run_div(input string tag, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
    int edges;
    logic busy_ok;
    issue(s, a, b);
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    wait_done(0, edges, busy_ok);
    expect_result(tag, s, a, b, edges, busy_ok);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int edges;
    logic busy_ok;
    logic seen_done;
    logic [31:0] rnd_b;
    n_tests = 0;
    n_fail = 0;
    reset = 1'b0; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_z", 32'(div_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_div("u100_7", 1'b0, 32'd100, 32'd7);
    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    run_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("u_3_max", 1'b0, 32'd3, 32'hFFFF_FFFF);
    run_div("dz_u", 1'b0, 32'd5, 32'd0);
    run_div("dz_s", 1'b1, 32'd5, 32'd0);
    run_div("dz_sneg", 1'b1, 32'hFFFF_FFF0, 32'd0);

    // Start at E5 while busy must be ignored.
    issue(1'b0, 32'd1000, 32'd7);
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(5, edges, busy_ok);
    expect_result("ovl", 1'b0, 32'd1000, 32'd7, edges, busy_ok);

    // Start in the done cycle is accepted.
    start = 1'b1; sign = 1'b0; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_pulse", 32'(done), 32'd0);
    check("b2b_busy0", 32'(busy), 32'd1);
    wait_done(0, edges, busy_ok);
    expect_result("b2b", 1'b0, 32'd9, 32'd3, edges, busy_ok);

    // Asynchronous reset mid-divide.
    issue(1'b1, 32'hFFFF_0000, 32'd3);
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_done", 32'(done), 32'd0);
    check("ar_q", quotient, 32'd0);
    check("ar_r", remainder, 32'd0);
    check("ar_z", 32'(div_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    check("ar_nodone", 32'(seen_done), 32'd0);
    run_div("ar_20_6", 1'b0, 32'd20, 32'd6);

    // Randomized operands, including small and zero divisors.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       rnd_b = 32'd0;
        1, 2:    rnd_b = 32'($urandom_range(1, 15));
        3:       rnd_b = -32'($urandom_range(1, 15));
        default: rnd_b = $urandom;
      endcase
      run_div("rnd", 1'($urandom_range(0, 1)), $urandom, rnd_b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
